// File: rtl/button_tick_bank.sv
// Multi-channel button synchroniser/debouncer emitting one-cycle press ticks.
// Optional auto-repeat while held is enabled by defining BUTTON_TICK_REPEAT_EN.
module button_tick_bank #(
  parameter int unsigned N_BTN         = 5,
  parameter int unsigned DEBOUNCE_CYC  = 1_000_000,
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic [N_BTN-1:0] i_BTN,
  output logic [N_BTN-1:0] o_TICK,
  output logic [N_BTN-1:0] o_HELD,
  output logic             o_ANY
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (N_BTN < 1 || DEBOUNCE_CYC < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("button_tick_bank: invalid parameter set");
  end

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [N_BTN-1:0] sync_meta, sync_lvl;
  state_t           state     [N_BTN];
  state_t           state_nxt [N_BTN];
  logic [CNT_W-1:0] cnt       [N_BTN];
  logic [CNT_W-1:0] cnt_nxt   [N_BTN];
  logic [N_BTN-1:0] press_c;
  logic [N_BTN-1:0] rep_tick_c;
  logic [N_BTN-1:0] tick_nxt, held_nxt;

  // Two-flop synchroniser for the raw asynchronous button levels
  always_ff @(negedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      sync_meta <= '0;
      sync_lvl  <= '0;
    end else begin
      sync_meta <= i_BTN;
      sync_lvl  <= sync_meta;
    end
  end

  // Per-channel FSM state and debounce counters
  always_ff @(negedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      for (int k = 0; k < int'(N_BTN); k++) begin
        state[k] <= RELEASED;
        cnt[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < int'(N_BTN); k++) begin
        state[k] <= state_nxt[k];
        cnt[k]   <= cnt_nxt[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < int'(N_BTN); k++) begin
      state_nxt[k] = state[k];
      cnt_nxt[k]   = cnt[k];
      press_c[k]   = 1'b0;
      case (state[k])
        RELEASED: begin
          if (sync_lvl[k]) begin
            state_nxt[k] = PRESS_WAIT;
            cnt_nxt[k]   = CNT_ONE;
          end
        end
        PRESS_WAIT: begin
          if (!sync_lvl[k]) begin
            state_nxt[k] = RELEASED;
          end else if (cnt[k] == CNT_LAST) begin
            state_nxt[k] = PRESSED;
            press_c[k]   = 1'b1;
          end else begin
            cnt_nxt[k] = cnt[k] + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!sync_lvl[k]) begin
            state_nxt[k] = RELEASE_WAIT;
            cnt_nxt[k]   = CNT_ONE;
          end
        end
        RELEASE_WAIT: begin
          if (sync_lvl[k]) begin
            state_nxt[k] = PRESSED;
          end else if (cnt[k] == CNT_LAST) begin
            state_nxt[k] = RELEASED;
          end else begin
            cnt_nxt[k] = cnt[k] + CNT_ONE;
          end
        end
        default: state_nxt[k] = RELEASED;
      endcase
    end
  end

`ifdef BUTTON_TICK_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] DLY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PER_LAST = REP_W'(REPEAT_PERIOD - 1);
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

  logic [REP_W-1:0] rep       [N_BTN];
  logic [REP_W-1:0] rep_nxt   [N_BTN];
  logic [N_BTN-1:0] rep_phase, rep_phase_nxt;

  always_ff @(negedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      rep_phase <= '0;
      for (int k = 0; k < int'(N_BTN); k++) rep[k] <= '0;
    end else begin
      rep_phase <= rep_phase_nxt;
      for (int k = 0; k < int'(N_BTN); k++) rep[k] <= rep_nxt[k];
    end
  end

  // Phase 0 waits for the initial delay, phase 1 paces the periodic repeats
  always_comb begin
    rep_phase_nxt = rep_phase;
    rep_tick_c    = '0;
    for (int k = 0; k < int'(N_BTN); k++) begin
      rep_nxt[k] = rep[k];
      if (press_c[k] || state_nxt[k] == RELEASED) begin
        rep_nxt[k]       = '0;
        rep_phase_nxt[k] = 1'b0;
      end else if (state[k] == PRESSED && sync_lvl[k]) begin
        if (!rep_phase[k] && rep[k] == DLY_LAST) begin
          rep_tick_c[k]    = 1'b1;
          rep_nxt[k]       = '0;
          rep_phase_nxt[k] = 1'b1;
        end else if (rep_phase[k] && rep[k] == PER_LAST) begin
          rep_tick_c[k] = 1'b1;
          rep_nxt[k]    = '0;
        end else begin
          rep_nxt[k] = rep[k] + REP_ONE;
        end
      end
    end
  end
`else
  assign rep_tick_c = '0;
`endif

  always_comb begin
    tick_nxt = press_c | rep_tick_c;
    held_nxt = '0;
    for (int k = 0; k < int'(N_BTN); k++) begin
      held_nxt[k] = (state_nxt[k] == PRESSED) || (state_nxt[k] == RELEASE_WAIT);
    end
  end

  // Registered outputs; o_ANY is aligned with o_TICK
  always_ff @(negedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      o_TICK <= '0;
      o_HELD <= '0;
      o_ANY  <= 1'b0;
    end else begin
      o_TICK <= tick_nxt;
      o_HELD <= held_nxt;
      o_ANY  <= |tick_nxt;
    end
  end

endmodule
